// File: rtl/forward_sequencer.sv
// Address/enable sequencer for one forward pass: streams NIN read pairs, replays the
// matching write pairs LAT cycles later, then pulses done for one cycle.
module forward_sequencer #(
   parameter int unsigned AWIDTH = 8,
   parameter int unsigned NIN    = 16,
   parameter int unsigned LAT    = 3,
   parameter int unsigned RBASE  = 0,
   parameter int unsigned WBASE  = 128
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_rd_en,
   output logic [AWIDTH-1:0] o_addread1,
   output logic [AWIDTH-1:0] o_addread2,
   output logic              o_wr_en,
   output logic [AWIDTH-1:0] o_addwrite1,
   output logic [AWIDTH-1:0] o_addwrite2
);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_t;

   localparam logic [AWIDTH-1:0] KLast  = AWIDTH'(NIN - 1);
   localparam logic [AWIDTH-1:0] RBaseA = AWIDTH'(RBASE);
   localparam logic [AWIDTH-1:0] WBaseA = AWIDTH'(WBASE);
   localparam logic [AWIDTH-1:0] One    = AWIDTH'(1);

   state_t            r_state, w_state;
   logic [AWIDTH-1:0] r_k, w_k;
   logic              r_busy, w_busy;
   logic              r_done, w_done;
   logic              r_rd_en, w_rd_en;
   logic [AWIDTH-1:0] r_ra1, w_ra1, r_ra2, w_ra2;
   logic              r_wr_en, w_wr_en;
   logic [AWIDTH-1:0] r_wk, w_wk;
   logic [AWIDTH-1:0] r_wa1, w_wa1, r_wa2, w_wa2;
   logic              w_last_wr;

   // Delay line of {valid, k}; stage 0 loads alongside the read-side output registers.
   logic              r_dv [LAT];
   logic [AWIDTH-1:0] r_dk [LAT];

   always_comb begin
      w_state   = r_state;
      w_k       = r_k;
      w_busy    = r_busy;
      w_done    = 1'b0;
      w_rd_en   = 1'b0;
      w_ra1     = r_ra1;
      w_ra2     = r_ra2;
      w_wr_en   = r_dv[LAT-1];
      w_wk      = r_wk;
      w_wa1     = r_wa1;
      w_wa2     = r_wa2;
      w_last_wr = r_wr_en && (r_wk == KLast);

      if (r_dv[LAT-1]) begin
         w_wk  = r_dk[LAT-1];
         w_wa1 = WBaseA + (r_dk[LAT-1] << 1);
         w_wa2 = WBaseA + (r_dk[LAT-1] << 1) + One;
      end

      unique case (r_state)
         StIdle, StDone: begin
            w_busy = 1'b0;
            if (i_start) begin
               w_state = StRead;
               w_k     = '0;
            end else begin
               w_state = StIdle;
            end
         end
         StRead: begin
            w_busy  = 1'b1;
            w_rd_en = 1'b1;
            w_ra1   = RBaseA + (r_k << 1);
            w_ra2   = RBaseA + (r_k << 1) + One;
            w_k     = r_k + One;
            if (r_k == KLast) begin
               w_state = StDrain;
            end
         end
         StDrain: begin
            w_busy = 1'b1;
            // The final write pair was presented last cycle: close the pass.
            if (w_last_wr) begin
               w_state = StDone;
               w_done  = 1'b1;
               w_busy  = 1'b0;
            end
         end
         default: begin
            w_state = StIdle;
            w_busy  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_k     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rd_en <= 1'b0;
         r_ra1   <= '0;
         r_ra2   <= '0;
         r_wr_en <= 1'b0;
         r_wk    <= '0;
         r_wa1   <= '0;
         r_wa2   <= '0;
         for (int i = 0; i < int'(LAT); i++) begin
            r_dv[i] <= 1'b0;
            r_dk[i] <= '0;
         end
      end else begin
         r_state <= w_state;
         r_k     <= w_k;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_rd_en <= w_rd_en;
         r_ra1   <= w_ra1;
         r_ra2   <= w_ra2;
         r_wr_en <= w_wr_en;
         r_wk    <= w_wk;
         r_wa1   <= w_wa1;
         r_wa2   <= w_wa2;
         r_dv[0] <= w_rd_en;
         r_dk[0] <= r_k;
         for (int i = 1; i < int'(LAT); i++) begin
            r_dv[i] <= r_dv[i-1];
            r_dk[i] <= r_dk[i-1];
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_rd_en     = r_rd_en;
   assign o_addread1  = r_ra1;
   assign o_addread2  = r_ra2;
   assign o_wr_en     = r_wr_en;
   assign o_addwrite1 = r_wa1;
   assign o_addwrite2 = r_wa2;

endmodule

// File: doc/forward_sequencer.md
# forward_sequencer

Address and enable sequencer sitting directly upstream of the forward neural stage (read memory → neuron array → write memory). On a start pulse it streams NIN read-address pairs into the two-port read memory. It then replays the matching write-address pairs to the write memory once the fixed read-to-result pipeline latency has elapsed, and reports completion with a one-cycle done pulse. It owns all pass-level control; the datapath stays a pure stream.

## Interface
Parameters:
- AWIDTH, 8, width of every address port
- NIN, 16, read/write address pairs per pass (1..2^(AWIDTH-1))
- LAT, 3, cycles from a read pair's issue to its result pair being valid at the write memory (1..16)
- RBASE, 0, first read address
- WBASE, 128, first write address

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a pass; sampled only when idle
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse after the last write of a pass
- rd_en  out  1  read pair valid this cycle
- addread1  out  AWIDTH  read address, port 1
- addread2  out  AWIDTH  read address, port 2
- wr_en  out  1  write pair valid this cycle
- addwrite1  out  AWIDTH  write address, port 1
- addwrite2  out  AWIDTH  write address, port 2

## Operation
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, all addresses 0, state IDLE, read counter 0, write delay line cleared.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: on start=1, go to READ with k=0.
- READ: per cycle drive rd_en=1, addread1=RBASE+2k, addread2=RBASE+2k+1. Increment k. After k=NIN-1 go to DRAIN, or to DONE directly if the last write falls in the same cycle.
- Write side: a LAT-deep shift register of {valid, k} is fed by the read side. When its output is valid, drive wr_en=1, addwrite1=WBASE+2k, addwrite2=WBASE+2k+1.
- DRAIN: rd_en=0. Stay until the last pair (k=NIN-1) has been written, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start in this cycle is accepted, and the next pass behaves as if started from IDLE.
- start is ignored while busy=1. It is level-sampled, so holding start high gives back-to-back passes separated by the DONE cycle.
- Address arithmetic is modulo 2^AWIDTH: base+offset wraps silently and no overflow flag exists.
- When rd_en=0 or wr_en=0, the corresponding addresses hold their last value. Consumers must qualify addresses with the enable.
- rst asserted mid-pass:
  - all outputs drop to reset values immediately (asynchronous);
  - in-flight write entries are discarded;
  - no done pulse is produced;
  - after rst deasserts, the block sits in IDLE until the next start.

## Timing
- Cycle 0 is the edge at which start=1 is sampled in IDLE.
- busy rises in cycle 1 and stays high through cycle NIN+LAT.
- Read pair k is driven in cycle 1+k, for k=0..NIN-1.
- Write pair k is driven in cycle 1+k+LAT.
- done pulses in cycle NIN+LAT+1.
- Total pass length is NIN+LAT+1 cycles, and reads and writes overlap whenever LAT<NIN.
- All outputs are registered, with no combinational path from start to any output.

## Test plan
- Default parameters, start pulse at cycle 0:
  - rd_en high in cycles 1–16, with addread1=0,2,…,30 and addread2=1,3,…,31;
  - wr_en high in cycles 4–19, with addwrite1=128,…,158 and addwrite2=129,…,159;
  - done=1 only in cycle 20, and busy high in cycles 1–19.
- start re-pulsed in cycles 5 and 12 of a default pass: no change to the address or enable sequence, and exactly one done pulse, in cycle 20.
- rst asserted asynchronously mid-cycle 8 and released at cycle 10:
  - busy, rd_en and wr_en go low without waiting for an edge;
  - no wr_en and no done appear afterwards;
  - a new start at cycle 15 gives a clean pass, with done in cycle 35.
- RBASE=250, WBASE=254, NIN=4, LAT=1:
  - addread1 runs 250,252,254,0 and addread2 runs 251,253,255,1;
  - addwrite1 runs 254,0,2,4 in cycles 2–5;
  - done is in cycle 6.
- start held high continuously, defaults: passes begin at cycles 0, 21 and 42, with rd_en in cycles 1–16 then 22–37, and done in cycles 20 and 41.
- NIN=1, LAT=1:
  - rd_en in cycle 1 with addresses 0/1;
  - wr_en in cycle 2 with addresses 128/129;
  - done in cycle 3, and the block is back in IDLE in cycle 4.
